// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// FSM state encoding, coin denominations and the item price table.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } state_t;

   localparam logic [7:0] COIN_10  = 8'd10;
   localparam logic [7:0] COIN_20  = 8'd20;
   localparam logic [7:0] COIN_50  = 8'd50;
   localparam logic [7:0] COIN_100 = 8'd100;

   localparam logic [7:0] ITEM1_PRICE  = 8'd10;
   localparam logic [7:0] ITEM2_PRICE  = 8'd20;
   localparam logic [7:0] ITEM3_PRICE  = 8'd50;
   localparam logic [7:0] ITEM4_PRICE  = 8'd80;
   localparam logic [7:0] ITEM5_PRICE  = 8'd100;
   localparam logic [7:0] ITEM6_PRICE  = 8'd120;
   localparam logic [7:0] ITEM7_PRICE  = 8'd150;
   localparam logic [7:0] ITEM8_PRICE  = 8'd200;
   localparam logic [7:0] ITEM9_PRICE  = 8'd220;
   localparam logic [7:0] ITEM10_PRICE = 8'd250;

   typedef struct packed {
      logic       valid;
      logic [7:0] price;
   } price_t;

   function automatic price_t price_of(input logic [3:0] code);
      price_t p;
      p.valid = 1'b1;
      p.price = 8'd0;
      case (code)
         4'd1:    p.price = ITEM1_PRICE;
         4'd2:    p.price = ITEM2_PRICE;
         4'd3:    p.price = ITEM3_PRICE;
         4'd4:    p.price = ITEM4_PRICE;
         4'd5:    p.price = ITEM5_PRICE;
         4'd6:    p.price = ITEM6_PRICE;
         4'd7:    p.price = ITEM7_PRICE;
         4'd8:    p.price = ITEM8_PRICE;
         4'd9:    p.price = ITEM9_PRICE;
         4'd10:   p.price = ITEM10_PRICE;
         default: p.valid = 1'b0;
      endcase
      return p;
   endfunction

   function automatic logic is_legal_coin(input logic [7:0] value);
      return (value == COIN_10) || (value == COIN_20) ||
             (value == COIN_50) || (value == COIN_100);
   endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest hopper denomination not exceeding the
// current credit, or 0 when no coin fits.
module vend_change_sel
   import vend_pkg::*;
(
   input  logic [7:0] credit,
   output logic [7:0] change_value
);

   always_comb begin
      if (credit >= COIN_100)     change_value = COIN_100;
      else if (credit >= COIN_50) change_value = COIN_50;
      else if (credit >= COIN_20) change_value = COIN_20;
      else if (credit >= COIN_10) change_value = COIN_10;
      else                        change_value = 8'd0;
   end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: collects coins into credit, validates
// selections, handshakes with the dispenser and pays change coin by coin.
module vend_txn_ctrl
   import vend_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CREDIT_MAX     = 255
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [7:0] coin_value,
   input  logic       select_valid,
   input  logic [3:0] item_code,
   input  logic       cancel,
   input  logic       vend_done,
   input  logic       change_ack,
   output logic       coin_reject,
   output logic       sel_error,
   output logic       vend_req,
   output logic [3:0] vend_item,
   output logic       change_valid,
   output logic [7:0] change_value,
   output logic [7:0] credit,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [7:0]    credit_nxt;
   logic [3:0]    vend_item_nxt;
   logic          coin_reject_nxt, sel_error_nxt, vend_req_nxt;
   logic          change_valid_nxt, busy_nxt;
   logic [8:0]    coin_sum;
   logic          coin_fits;
   logic [7:0]    pick;
   price_t        sel_price;

   // 9-bit sum so an overflowing coin is caught before it wraps the credit
   assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
   assign coin_fits = (coin_sum <= 9'(CREDIT_MAX));
   assign sel_price = price_of(item_code);

   vend_change_sel u_change_sel (
      .credit       (credit),
      .change_value (pick)
   );

   assign change_value = change_valid ? pick : 8'd0;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt        = state;
      credit_nxt       = credit;
      timer_nxt        = '0;
      vend_item_nxt    = vend_item;
      vend_req_nxt     = vend_req;
      change_valid_nxt = change_valid;
      coin_reject_nxt  = 1'b0;
      sel_error_nxt    = 1'b0;

      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (cancel) begin
               coin_reject_nxt = coin_valid;
               if (state == ST_COLLECT) begin
                  state_nxt        = (credit != 8'd0) ? ST_CHANGE : ST_IDLE;
                  change_valid_nxt = (credit != 8'd0);
               end
            end else if (coin_valid) begin
               if (is_legal_coin(coin_value) && coin_fits) begin
                  credit_nxt = coin_sum[7:0];
                  state_nxt  = ST_COLLECT;
               end else begin
                  coin_reject_nxt = 1'b1;
               end
            end else if (select_valid) begin
               if (!sel_price.valid || (credit < sel_price.price)) begin
                  sel_error_nxt = 1'b1;
               end else begin
                  credit_nxt    = credit - sel_price.price;
                  vend_item_nxt = item_code;
                  vend_req_nxt  = 1'b1;
                  state_nxt     = ST_VEND;
               end
            end else if (state == ST_COLLECT) begin
               // Quiet COLLECT cycles count toward the automatic refund
               if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_nxt        = (credit != 8'd0) ? ST_CHANGE : ST_IDLE;
                  change_valid_nxt = (credit != 8'd0);
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
         end

         ST_VEND: begin
            coin_reject_nxt = coin_valid;
            sel_error_nxt   = select_valid && !coin_valid && !cancel;
            if (vend_done) begin
               vend_req_nxt     = 1'b0;
               state_nxt        = (credit != 8'd0) ? ST_CHANGE : ST_IDLE;
               change_valid_nxt = (credit != 8'd0);
            end
         end

         ST_CHANGE: begin
            coin_reject_nxt = coin_valid;
            sel_error_nxt   = select_valid && !coin_valid && !cancel;
            if (change_ack) begin
               credit_nxt = credit - pick;
               if (credit == pick) begin
                  state_nxt        = ST_IDLE;
                  change_valid_nxt = 1'b0;
               end
            end
         end

         default: state_nxt = ST_IDLE;
      endcase

      busy_nxt = (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         credit       <= 8'd0;
         timer        <= '0;
         vend_item    <= 4'd0;
         vend_req     <= 1'b0;
         change_valid <= 1'b0;
         coin_reject  <= 1'b0;
         sel_error    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         credit       <= credit_nxt;
         timer        <= timer_nxt;
         vend_item    <= vend_item_nxt;
         vend_req     <= vend_req_nxt;
         change_valid <= change_valid_nxt;
         coin_reject  <= coin_reject_nxt;
         sel_error    <= sel_error_nxt;
         busy         <= busy_nxt;
      end
   end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Transaction sequencer for the vending machine. Accumulates inserted coins into a credit register and validates item selections against the item price table. It then drives a request/done handshake to the dispenser mechanism and pays out change one coin at a time through a valid/ack handshake. Sits between the coin acceptor/keypad front end and the dispenser/change-hopper actuators.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT with nonzero credit before automatic refund
CREDIT_MAX, 255, credit ceiling; a coin that would exceed it is rejected

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
coin_valid  in  1  one-cycle strobe, coin inserted
coin_value  in  8  coin denomination; legal values 10, 20, 50, 100
select_valid  in  1  one-cycle strobe, item selected
item_code  in  4  item number; legal 1..10
cancel  in  1  one-cycle strobe, user requests refund
vend_done  in  1  dispenser finished current item
change_ack  in  1  hopper accepted current change coin
coin_reject  out  1  one-cycle pulse, coin returned (illegal, overflow, or wrong state)
sel_error  out  1  one-cycle pulse, illegal code or insufficient credit
vend_req  out  1  held high until vend_done
vend_item  out  4  item code being vended, stable while vend_req high
change_valid  out  1  change coin offered, held until change_ack
change_value  out  8  denomination of offered coin
credit  out  8  current credit
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset: state IDLE; credit 0; all pulses 0; vend_req 0; vend_item 0; change_valid 0; change_value 0; busy 0; timeout counter 0.
- States: IDLE, COLLECT, VEND, CHANGE.
- Price table (item 1..10): 10, 20, 50, 80, 100, 120, 150, 200, 220, 250.
- IDLE/COLLECT, legal coin:
  - If credit+coin_value <= CREDIT_MAX (9-bit compare): credit += coin_value at next edge and go to COLLECT.
  - Otherwise: coin_reject pulse, credit unchanged.
- IDLE/COLLECT, illegal coin value: coin_reject pulse.
- Select in IDLE/COLLECT:
  - Illegal code or credit < price: sel_error pulse, state unchanged.
  - Otherwise at edge N: credit <= credit - price, vend_item <= item_code, state VEND. vend_req is high from cycle N+1.
- Coin and select in the same cycle: coin processed; select ignored with no pulse.
- Cancel in the same cycle as a coin or select: cancel wins; coin gets coin_reject; select is ignored.
- Cancel in COLLECT: go to CHANGE if credit > 0, else IDLE. Cancel in IDLE, VEND or CHANGE is ignored.
- VEND:
  - vend_req held high.
  - On vend_done, next state is CHANGE if credit > 0, else IDLE.
  - vend_done outside VEND is ignored.
- CHANGE:
  - change_valid high.
  - change_value is the largest of 100/50/20/10 that is <= credit, recomputed each cycle from registered credit.
  - On change_ack: credit -= change_value. When credit reaches 0, go to IDLE with change_valid low on the same edge.
  - Credit is always a multiple of 10, so change is exact.
- Coins in VEND/CHANGE: coin_reject. Selects in VEND/CHANGE: sel_error.
- Timeout:
  - Counter runs only in COLLECT and clears on any coin, select or cancel strobe.
  - Reaching TIMEOUT_CYCLES-1 moves to CHANGE (refund) on the next edge.
- Reset asserted mid-VEND or mid-CHANGE: immediate return to reset values. Credit is lost by design; the front end logs the event.
- busy = (state==VEND || state==CHANGE), registered.

Decomposition:
- Package vend_pkg: state enum; item price constants ITEM1..ITEM10_PRICE; coin denominations COIN_10/20/50/100; function price_of(item_code) returning 8-bit price and valid bit.
- One sub-module, vend_change_sel: combinational greedy denomination pick from credit.
- Everything else stays in vend_txn_ctrl.

Test Plan:
- Coins 50 then 20, select item 3 (50) -> credit 70 then 20; vend_req/vend_item=3 until vend_done; one change coin 20; IDLE, credit 0.
- Credit 60, select item 4 (80) -> sel_error one cycle, credit 60, still COLLECT. Select item 11 -> sel_error.
- Credit 200, coin 100 -> coin_reject, credit 200. Coin value 25 in IDLE -> coin_reject, credit 0.
- Credit 180, cancel -> change sequence 100, 50, 20, 10. With change_ack delayed 3 cycles on each coin, change_value holds steady and busy stays high throughout.
- Credit 30, no activity TIMEOUT_CYCLES (8 for test) -> CHANGE entered, coins 20 then 10 refunded.
- During VEND, inject coin 10 and cancel -> coin_reject, cancel ignored. Assert reset mid-CHANGE -> all outputs at reset values next cycle.
